// File: rtl/cpu31_pkg.sv
// Shared CPU31 definitions: datapath widths, register-file indices and ALU opcodes.
package cpu31_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int REG_NUM = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13
  } alu_op_e;

endpackage

// File: rtl/regfile.sv
// CPU31 register file: 2 read + 1 debug read, 1 write gated by overflow trap, hardwired $0.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to rdata1/rdata2.
module regfile
  import cpu31_pkg::*;
#(
  parameter int DATA_W = cpu31_pkg::DATA_W,
  parameter int ADDR_W = cpu31_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              ovf_kill,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [31:0]       wr_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [31:0]       wr_cnt_q;
  logic [31:0]       wr_cnt_d;
  logic              commit;

  assign commit   = we & ~ovf_kill & (waddr != '0);
  assign wr_cnt_d = wr_cnt_q + 32'd1;

  // Entry 0 is reset and never written, so it holds zero for the life of the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      wr_cnt_q <= '0;
    end else if (commit) begin
      regs_q[waddr] <= wdata;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  function automatic logic [DATA_W-1:0] rd_word(input logic [ADDR_W-1:0] a);
    rd_word = (a == '0) ? '0 : regs_q[a];
  endfunction

  always_comb begin
    rdata1   = rd_word(raddr1);
    rdata2   = rd_word(raddr2);
    dbg_data = rd_word(dbg_addr);
`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed during reset so reads stay zero while rst is high.
    if (commit && !rst && raddr1 == waddr) rdata1 = wdata;
    if (commit && !rst && raddr2 == waddr) rdata2 = wdata;
`endif
  end

  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_regfile.sv
// Directed self-checking bench for regfile; expectations follow REGFILE_BYPASS_EN if defined.
module tb_regfile;
  import cpu31_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic        ovf_kill = 1'b0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [31:0] wr_cnt;

  int n_checks = 0;
  int n_errors = 0;

  regfile dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .ovf_kill (ovf_kill),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_cnt   (wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive a write on the falling edge, let it land on the next rising edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic kill);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d; ovf_kill = kill;
    @(posedge clk);
    #1;
    we = 1'b0; ovf_kill = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_same;

    rst = 1'b1;
    #12;
    rst = 1'b0;
    check("reset_cnt", wr_cnt, 32'd0);
    raddr1 = 5'd7;
    #1 check("reset_rd", rdata1, 32'd0);

    // Preload 1..31 with index*0x01010101.
    for (int i = 1; i < 32; i++) wr(i[4:0], i * 32'h01010101, 1'b0);
    @(negedge clk);
    check("preload_cnt", wr_cnt, 32'd31);
    raddr1 = 5'd31; raddr2 = 5'd17; dbg_addr = 5'd1;
    #1;
    check("preload_r31", rdata1, 32'h1F1F1F1F);
    check("preload_r17", rdata2, 32'h11111111);
    check("preload_dbg1", dbg_data, 32'h01010101);

    // Mid-cycle reset pulse clears everything immediately.
    #2 rst = 1'b1;
    #1;
    check("rst_rd1", rdata1, 32'd0);
    check("rst_rd2", rdata2, 32'd0);
    check("rst_dbg", dbg_data, 32'd0);
    check("rst_cnt", wr_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic write/read.
    wr(5'd8, 32'hDEADBEEF, 1'b0);
    raddr1 = 5'd8;
    #1 check("basic_rd1", rdata1, 32'hDEADBEEF);
    check("basic_cnt", wr_cnt, 32'd1);
    raddr2 = 5'd8;
    #1 check("basic_rd2", rdata2, 32'hDEADBEEF);

    // $0 protection.
    wr(5'd0, 32'hFFFFFFFF, 1'b0);
    raddr1 = 5'd0; dbg_addr = 5'd0;
    #1 check("zero_rd", rdata1, 32'd0);
    check("zero_dbg", dbg_data, 32'd0);
    check("zero_cnt", wr_cnt, 32'd1);

    // Overflow kill.
    wr(5'd5, 32'h7FFFFFFF, 1'b0);
    wr(5'd5, 32'h80000000, 1'b1);
    raddr1 = 5'd5;
    #1 check("kill_rd", rdata1, 32'h7FFFFFFF);
    check("kill_cnt", wr_cnt, 32'd2);
    wr(5'd5, 32'h80000000, 1'b0);
    #1 check("nokill_rd", rdata1, 32'h80000000);
    check("nokill_cnt", wr_cnt, 32'd3);

    // Same-cycle read of the register being written.
    wr(5'd3, 32'h11, 1'b0);
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h22;
`else
    exp_same = 32'h11;
`endif
    @(negedge clk);
    we = 1'b1; waddr = 5'd3; wdata = 32'h22; raddr2 = 5'd3; dbg_addr = 5'd3;
    #1;
    check("same_pre_rd2", rdata2, exp_same);
    check("same_pre_dbg", dbg_data, 32'h11);
    @(posedge clk);
    #1;
    we = 1'b0;
    check("same_post_rd2", rdata2, 32'h22);
    check("same_cnt", wr_cnt, 32'd5);

    // Disabled write with arbitrary address/data leaves state intact.
    @(negedge clk);
    we = 1'b0; waddr = 5'd3; wdata = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    check("nowe_rd2", rdata2, 32'h22);
    check("nowe_cnt", wr_cnt, 32'd5);

    // Counter wrap via backdoor preload of the count.
    @(negedge clk);
    dut.wr_cnt_q = 32'hFFFFFFFF;
    #1 check("wrap_pre", wr_cnt, 32'hFFFFFFFF);
    wr(5'd10, 32'h1234, 1'b0);
    check("wrap_cnt", wr_cnt, 32'd0);

    // Reset racing a commit: reset wins.
    wr(5'd9, 32'h99, 1'b0);
    raddr1 = 5'd9;
    #1 check("race_pre", rdata1, 32'h99);
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = 32'h55; rst = 1'b1;
    raddr2 = 5'd9;
    #1;
    check("race_rd2_rsthigh", rdata2, 32'd0);
    @(posedge clk);
    #1;
    check("race_rd", rdata1, 32'd0);
    check("race_cnt", wr_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    we = 1'b0;

    // First commit after reset release lands normally.
    wr(5'd9, 32'h77, 1'b0);
    #1 check("post_rst_rd", rdata1, 32'h77);
    check("post_rst_cnt", wr_cnt, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- 32 x 32-bit MIPS general-purpose register file for the CPU31 single-cycle core.
- Sits directly around the ALU:
  - Read ports 1/2 drive ALU operands a/b.
  - Write port consumes the ALU result r and is gated by the ALU overflow flag.
- Enforces hardwired $0.
- Drops writes when ADD/SUB overflow (trap semantics).
- Counts committed writes for debug.

Parameters:
- DATA_W, 32, register and data width.
- ADDR_W, 5, register address width; depth is 2**ADDR_W.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- we  in  1  write enable from control.
- waddr  in  5  destination register index (rd/rt).
- wdata  in  32  write data (ALU r or memory data, muxed upstream).
- ovf_kill  in  1  ALU overflow AND instruction is trapping (add/sub/addi); suppresses the write.
- raddr1  in  5  rs index.
- raddr2  in  5  rt index.
- rdata1  out  32  rs value, to ALU a.
- rdata2  out  32  rt value, to ALU b.
- dbg_addr  in  5  debug read index (board display).
- dbg_data  out  32  debug read value.
- wr_cnt  out  32  number of committed register writes since reset.

Behaviour:
- Reset (asynchronous, active-high, on rst assertion regardless of clk):
  - Registers 1..31 <= 0.
  - wr_cnt <= 0.
  - All read outputs evaluate to 0 while rst is high.
- Commit condition: commit = we & ~ovf_kill & (waddr != 0).
  - On a clk rising edge with commit=1: reg[waddr] <= wdata and wr_cnt <= wr_cnt + 1.
  - wr_cnt wraps mod 2**32 (0xFFFFFFFF + 1 -> 0).
  - commit=0: no state change, wr_cnt holds.
- Register 0:
  - Never stored.
  - Any read of index 0 returns 0.
  - A write to 0 is not a commit and does not increment wr_cnt.
- Reads (rdata1, rdata2, dbg_data): combinational, zero-cycle latency from address change.
- Same-cycle read of the register being written: returns the pre-edge (old) value. The new value is visible after the edge. See optional feature for the exception.
- Both read ports addressing the same register return identical data.
- rst asserted in the same cycle as a commit: reset wins; register and wr_cnt end at 0.
- rst released: the first edge with commit=1 writes normally.
- X on waddr/wdata with commit=0 must not corrupt state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When commit=1 and raddrN == waddr (N=1,2, nonzero), rdataN = wdata combinationally in the same cycle.
  - dbg_data is not bypassed.
  - Used when the write port is retimed into a pipelined variant.
- Undefined: no bypass; same-cycle reads see the old value as above.

Decomposition:
- Shared package cpu31_pkg:
  - DATA_W=32, ADDR_W=5, REG_NUM=32, REG_ZERO=5'd0.
  - Typedefs word_t (32-bit) and reg_idx_t (5-bit).
  - Same package supplies the ALU opcode constants used elsewhere.
- No sub-module; storage array, read muxes, bypass and counter all live in regfile.

Test Plan:
- Reset sweep: preload regs 1..31 = index*0x01010101, pulse rst mid-cycle (not on an edge) -> all reads 0 immediately, wr_cnt=0.
- Basic write/read: we=1, waddr=8, wdata=0xDEADBEEF, one edge -> rdata1 (raddr1=8) = 0xDEADBEEF, wr_cnt=1; set raddr1=raddr2=8 -> both 0xDEADBEEF.
- $0 protection: we=1, waddr=0, wdata=0xFFFFFFFF -> rdata1 at index 0 = 0, wr_cnt unchanged.
- Overflow kill: reg5=0x7FFFFFFF; write 0x80000000 to reg5 with ovf_kill=1 -> reg5 stays 0x7FFFFFFF, wr_cnt unchanged; repeat with ovf_kill=0 -> reg5=0x80000000.
- Same-cycle read: reg3=0x11; in one cycle write 0x22 to reg3 with raddr2=3 -> rdata2=0x11 before the edge (0x22 if REGFILE_BYPASS_EN), 0x22 after the edge in both builds.
- Counter wrap and reset race: force 0xFFFFFFFF committed writes (or preload via backdoor), one more commit -> wr_cnt=0; commit with rst high -> target reg 0, wr_cnt 0.
